// File: rtl/reg_display_pkg.sv
// Shared constants and state encoding for the register-display path
// (snapshot buffer and VGA register writer).
package reg_display_pkg;

   localparam int IDX_W    = 5;
   localparam int NUM_REGS = 32;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 9;

   localparam logic [ADDR_W-1:0] BASE_ADDR = 9'h1E0;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      WAIT_SWAP
   } snap_state_t;

endpackage

// File: rtl/reg_bank_2x.sv
// Two banks of NUM_REGS x DATA_W shadow registers: one written by the
// snapshot filler, one read by the display through a registered port.
module reg_bank_2x
   import reg_display_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_bank,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2][NUM_REGS];

   // Both banks clear on reset so a stale image never survives an abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               mem[b][i] <= '0;
            end
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
         end
         rd_data <= mem[rd_bank][rd_idx];
      end
   end

endmodule

// File: rtl/reg_snapshot_buffer.sv
// Copies the CPU register image out of data RAM into the back bank and
// exposes it to the display only after a frame boundary swap.
module reg_snapshot_buffer
   import reg_display_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              snap_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   input  logic [IDX_W-1:0]  disp_addr,
   output logic [DATA_W-1:0] disp_value,
   input  logic              frame_done,
   output logic              busy,
   output logic              snap_valid
);

   snap_state_t      state, state_next;
   logic [IDX_W:0]   rd_idx, rd_idx_next;
   logic             pending, pending_next;
   logic             front_sel, front_next;
   logic             valid_next;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rd_idx     <= '0;
         pending    <= 1'b0;
         front_sel  <= 1'b0;
         snap_valid <= 1'b0;
      end else begin
         state      <= state_next;
         rd_idx     <= rd_idx_next;
         pending    <= pending_next;
         front_sel  <= front_next;
         snap_valid <= valid_next;
      end
   end

   // RAM data lags the issued address by one cycle, so the write index is
   // always one behind rd_idx; in DRAIN rd_idx has reached NUM_REGS.
   assign wr_idx = rd_idx[IDX_W-1:0] - IDX_W'(1);

   always_comb begin
      state_next   = state;
      rd_idx_next  = rd_idx;
      pending_next = pending;
      front_next   = front_sel;
      valid_next   = snap_valid;
      ram_rden     = 1'b0;
      ram_addr     = BASE_ADDR;
      wr_en        = 1'b0;
      busy         = (state != IDLE);

      case (state)
         IDLE: begin
            if (snap_req) begin
               state_next  = FILL;
               rd_idx_next = '0;
            end
         end
         FILL: begin
            ram_rden    = 1'b1;
            ram_addr    = BASE_ADDR + ADDR_W'(rd_idx[IDX_W-1:0]);
            wr_en       = (rd_idx != '0);
            rd_idx_next = rd_idx + (IDX_W+1)'(1);
            if (snap_req) pending_next = 1'b1;
            if (rd_idx == (IDX_W+1)'(NUM_REGS-1)) state_next = DRAIN;
         end
         DRAIN: begin
            wr_en      = 1'b1;
            state_next = WAIT_SWAP;
            if (snap_req) pending_next = 1'b1;
         end
         WAIT_SWAP: begin
            if (frame_done) begin
               front_next = ~front_sel;
               valid_next = 1'b1;
               if (pending || snap_req) begin
                  state_next   = FILL;
                  rd_idx_next  = '0;
                  pending_next = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else if (snap_req) begin
               pending_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   reg_bank_2x u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_bank (~front_sel),
      .wr_idx  (wr_idx),
      .wr_data (ram_q),
      .rd_bank (front_sel),
      .rd_idx  (disp_addr),
      .rd_data (disp_value)
   );

endmodule

// File: tb/tb_reg_snapshot_buffer.sv
// Scoreboard bench for reg_snapshot_buffer: stimulus pushes expected
// outputs from a snapshot-level model, a monitor pops and compares them.
module tb_reg_snapshot_buffer;
   import reg_display_pkg::*;

   logic              clk = 1'b0;
   logic              reset, snap_req, frame_done;
   logic              ram_rden, busy, snap_valid;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_q, disp_value;
   logic [IDX_W-1:0]  disp_addr;

   always #10 clk = ~clk;

   reg_snapshot_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .snap_req   (snap_req),
      .ram_addr   (ram_addr),
      .ram_rden   (ram_rden),
      .ram_q      (ram_q),
      .disp_addr  (disp_addr),
      .disp_value (disp_value),
      .frame_done (frame_done),
      .busy       (busy),
      .snap_valid (snap_valid)
   );

   logic [DATA_W-1:0] ram_mem [512];

   always @(posedge clk) begin
      if (ram_rden) ram_q <= ram_mem[ram_addr];
   end

   typedef struct {
      logic [DATA_W-1:0] disp;
      logic              rden;
      logic [ADDR_W-1:0] addr;
      logic              busy;
      logic              valid;
   } exp_t;

   exp_t exp_q[$];

   // Snapshot-level model: fill position (-1 = not filling, NUM_REGS = last
   // data landing), waiting-for-frame flag, pending request, two images.
   logic [DATA_W-1:0] m_bank [2][NUM_REGS];
   int  m_pos   = -1;
   bit  m_wait  = 0;
   bit  m_pend  = 0;
   bit  m_front = 0;
   bit  m_valid = 0;
   bit  poke_en = 0;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act === want) begin
         passes++;
      end else begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic apply_stimulus(input bit req, input bit fd, input logic [IDX_W-1:0] addr, input bit rst);
      exp_t e;
      @(negedge clk);
      if (poke_en && $urandom_range(0, 3) == 0) begin
         ram_mem[int'(BASE_ADDR) + $urandom_range(0, NUM_REGS-1)] = $urandom;
      end
      reset      = rst;
      snap_req   = req;
      frame_done = fd;
      disp_addr  = addr;
      e.disp = rst ? '0 : m_bank[m_front ? 1 : 0][addr];
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_REGS; i++) m_bank[b][i] = '0;
         m_pos = -1; m_wait = 0; m_pend = 0; m_front = 0; m_valid = 0;
      end else if (m_pos >= 0 && m_pos < NUM_REGS) begin
         m_bank[m_front ? 0 : 1][m_pos] = ram_mem[int'(BASE_ADDR) + m_pos];
         m_pos++;
         if (req) m_pend = 1;
      end else if (m_pos == NUM_REGS) begin
         m_pos  = -1;
         m_wait = 1;
         if (req) m_pend = 1;
      end else if (m_wait) begin
         if (fd) begin
            m_front = !m_front;
            m_valid = 1;
            m_wait  = 0;
            if (m_pend || req) begin
               m_pos  = 0;
               m_pend = 0;
            end
         end else if (req) begin
            m_pend = 1;
         end
      end else if (req) begin
         m_pos = 0;
      end
      e.rden  = (m_pos >= 0 && m_pos < NUM_REGS);
      e.addr  = e.rden ? BASE_ADDR + ADDR_W'(m_pos) : BASE_ADDR;
      e.busy  = (m_pos >= 0) || m_wait;
      e.valid = m_valid;
      exp_q.push_back(e);
   endtask

   task automatic idle_reads(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 0, IDX_W'($urandom), 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_field("disp_value", disp_value, e.disp);
            check_field("ram_rden", 32'(ram_rden), 32'(e.rden));
            check_field("ram_addr", 32'(ram_addr), 32'(e.addr));
            check_field("busy", 32'(busy), 32'(e.busy));
            check_field("snap_valid", 32'(snap_valid), 32'(e.valid));
         end
      end
   end

   initial begin
      int guard;
      reset = 1; snap_req = 0; frame_done = 0; disp_addr = '0;
      for (int a = 0; a < 512; a++) ram_mem[a] = $urandom;
      for (int k = 0; k < NUM_REGS; k++) ram_mem[int'(BASE_ADDR) + k] = 32'hA500_0000 + k;

      repeat (3) apply_stimulus(0, 0, '0, 1);
      for (int k = 0; k < NUM_REGS; k++) apply_stimulus(0, 0, IDX_W'(k), 0);

      // First snapshot, then swap and read selected registers.
      apply_stimulus(1, 0, '0, 0);
      idle_reads(45);
      apply_stimulus(0, 1, 5'd7, 0);
      apply_stimulus(0, 0, 5'd7, 0);
      apply_stimulus(0, 0, 5'd31, 0);
      apply_stimulus(0, 1, 5'd3, 0);
      apply_stimulus(0, 0, 5'd3, 0);

      // New image; requests during FILL and WAIT_SWAP merge into one refill.
      for (int k = 0; k < NUM_REGS; k++) ram_mem[int'(BASE_ADDR) + k] = 32'h5A00_0000 + k;
      apply_stimulus(1, 0, '0, 0);
      idle_reads(5);
      apply_stimulus(1, 0, 5'd9, 0);
      guard = 0;
      while (m_pos >= 0 && guard < 100) begin idle_reads(1); guard++; end
      apply_stimulus(1, 0, 5'd4, 0);
      apply_stimulus(1, 0, 5'd4, 0);
      idle_reads(5);
      apply_stimulus(0, 1, 5'd0, 0);

      // frame_done coinciding with DRAIN is ignored; the next one swaps.
      guard = 0;
      while (m_pos != NUM_REGS && guard < 100) begin idle_reads(1); guard++; end
      apply_stimulus(0, 1, 5'd12, 0);
      idle_reads(4);
      apply_stimulus(0, 1, 5'd12, 0);
      idle_reads(3);

      // Reset in the middle of a fill.
      apply_stimulus(1, 0, '0, 0);
      guard = 0;
      while (m_pos != 15 && guard < 100) begin idle_reads(1); guard++; end
      apply_stimulus(0, 0, '0, 1);
      for (int k = 0; k < NUM_REGS; k++) apply_stimulus(0, 0, IDX_W'(k), 0);

      // Random traffic with RAM churn.
      poke_en = 1;
      for (int i = 0; i < 1500; i++) begin
         apply_stimulus($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
                        IDX_W'($urandom), $urandom_range(0, 499) == 0);
      end
      poke_en = 0;
      idle_reads(2);

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin @(posedge clk); guard++; end
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
